// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: datapath widths, fetch FSM states and payload types.
package cpu_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned IMM_W   = 10;
  localparam int unsigned OPC_W   = 6;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_t;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc;
  } fetch_word_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives the imem read handshake, parks a word while stalled,
// and drains a stale in-flight request after a redirect.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall_in,
  input  logic               branch_taken,
  input  logic [XLEN-1:0]    branch_target,
  output logic               imem_req,
  output logic [XLEN-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               valid_out,
  output logic [INSTR_W-1:0] instr_out,
  output logic [XLEN-1:0]    pc_out,
  output logic [IMM_W-1:0]   imm_out,
  output logic [OPC_W-1:0]   opcode_out
);

  fetch_state_t    state, state_d;
  logic [XLEN-1:0] pc, pc_d, addr_d;
  logic            req_d, valid_d;
  fetch_word_t     out_q, out_d, hold_q, hold_d;

  logic            ack;
  logic [XLEN-1:0] pc_inc;
  logic [XLEN-1:0] target;

  // An ack is only honoured against an outstanding request.
  assign ack    = imem_ack & imem_req;
  assign pc_inc = pc + XLEN'(4);
  assign target = align_word(branch_target);

  // Next-state, pc, handshake and output-register decisions.
  always_comb begin
    state_d = state;
    pc_d    = pc;
    addr_d  = imem_addr;
    req_d   = imem_req;
    valid_d = valid_out;
    out_d   = out_q;
    hold_d  = hold_q;

    unique case (state)
      ST_FETCH: begin
        req_d = 1'b1;
        if (branch_taken) begin
          pc_d    = target;
          valid_d = 1'b0;
          hold_d  = '0;
          // A request still in flight must complete on its old address before redirecting.
          if (imem_req && !imem_ack) begin
            state_d = ST_DRAIN;
          end else begin
            addr_d = target;
          end
        end else if (ack) begin
          pc_d   = pc_inc;
          addr_d = pc_inc;
          if (stall_in) begin
            hold_d  = '{instr: imem_rdata, pc: imem_addr};
            req_d   = 1'b0;
            state_d = ST_HOLD;
          end else begin
            out_d   = '{instr: imem_rdata, pc: imem_addr};
            valid_d = 1'b1;
          end
        end else if (!stall_in) begin
          valid_d = 1'b0;
        end
      end

      ST_HOLD: begin
        if (branch_taken) begin
          pc_d    = target;
          addr_d  = target;
          req_d   = 1'b1;
          valid_d = 1'b0;
          hold_d  = '0;
          state_d = ST_FETCH;
        end else if (!stall_in) begin
          out_d   = hold_q;
          valid_d = 1'b1;
          hold_d  = '0;
          req_d   = 1'b1;
          state_d = ST_FETCH;
        end
      end

      ST_DRAIN: begin
        req_d   = 1'b1;
        valid_d = 1'b0;
        if (branch_taken) begin
          pc_d = target;
        end
        // Stale data is dropped; a redirect arriving with the ack still wins.
        if (imem_ack) begin
          addr_d  = branch_taken ? target : pc;
          state_d = ST_FETCH;
        end
      end

      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_FETCH;
      pc        <= RESET_PC;
      imem_addr <= RESET_PC;
      imem_req  <= 1'b0;
      valid_out <= 1'b0;
      out_q     <= '0;
      hold_q    <= '0;
    end else begin
      state     <= state_d;
      pc        <= pc_d;
      imem_addr <= addr_d;
      imem_req  <= req_d;
      valid_out <= valid_d;
      out_q     <= out_d;
      hold_q    <= hold_d;
    end
  end

  assign instr_out  = out_q.instr;
  assign pc_out     = out_q.pc;
  assign imm_out    = out_q.instr[IMM_W-1:0];
  assign opcode_out = out_q.instr[INSTR_W-1 -: OPC_W];

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: vector table for stall/branch corners, a scoreboard
// stream under random stall/ack, a wrapping-PC instance, and async reset mid-HOLD.
`timescale 1ns/1ps
module tb_fetch_stage;
  import cpu_pkg::*;

  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;
  localparam logic [31:0] WKEY    = 32'hA5C3_0F96;

  logic        clk;
  logic        reset;
  logic        stall_in, branch_taken, imem_ack;
  logic [31:0] branch_target, imem_rdata;
  logic        imem_req, valid_out;
  logic [31:0] imem_addr, instr_out, pc_out;
  logic [9:0]  imm_out;
  logic [5:0]  opcode_out;

  logic        w_stall, w_branch, w_ack;
  logic [31:0] w_target, w_rdata;
  logic        w_req, w_valid;
  logic [31:0] w_addr, w_instr, w_pc;
  logic [9:0]  w_imm;
  logic [5:0]  w_opc;

  fetch_stage dut (
    .clk(clk), .reset(reset), .stall_in(stall_in), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .valid_out(valid_out),
    .instr_out(instr_out), .pc_out(pc_out), .imm_out(imm_out), .opcode_out(opcode_out)
  );

  fetch_stage #(.RESET_PC(WRAP_PC)) dut_w (
    .clk(clk), .reset(reset), .stall_in(w_stall), .branch_taken(w_branch),
    .branch_target(w_target), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(w_ack), .imem_rdata(w_rdata), .valid_out(w_valid),
    .instr_out(w_instr), .pc_out(w_pc), .imm_out(w_imm), .opcode_out(w_opc)
  );

  // Memory models: main instance returns its address, wrap instance a keyed pattern.
  assign imem_rdata = imem_addr;
  assign w_rdata    = w_addr ^ WKEY;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        ack;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic s, input logic b, input logic [31:0] t, input logic a,
                              input logic r, input logic [31:0] ad, input logic v,
                              input logic [31:0] p);
    vec_t x;
    x.stall = s; x.br = b; x.tgt = t; x.ack = a;
    x.e_req = r; x.e_addr = ad; x.e_valid = v; x.e_pc = p;
    return x;
  endfunction

  logic [31:0] sb[$];
  logic [31:0] exp_fetch, exp_pc, e, wa, wp, wi;
  logic        exp_valid, s, a;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; stall_in = 1'b0; branch_taken = 1'b0; imem_ack = 1'b1;
    branch_target = '0;
    w_stall = 1'b0; w_branch = 1'b0; w_ack = 1'b1; w_target = '0;

    // Reset values, with an ack present that must be ignored.
    step(); step();
    check("rst_req", imem_req, 1'b0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", valid_out, 1'b0);
    check("rst_instr", instr_out, 32'h0);
    check("rst_pc", pc_out, 32'h0);
    check("rst_imm", 32'(imm_out), 32'h0);
    check("rst_opc", 32'(opcode_out), 32'h0);
    check("rst_w_addr", w_addr, WRAP_PC);
    check("rst_w_req", w_req, 1'b0);

    //         stall br tgt            ack  req addr          valid pc_out
    vecs.push_back(mk(0, 0, 32'h0,   0,   1, 32'h000, 0, 32'h000));
    vecs.push_back(mk(0, 0, 32'h0,   1,   1, 32'h004, 1, 32'h000));
    vecs.push_back(mk(0, 0, 32'h0,   1,   1, 32'h008, 1, 32'h004));
    vecs.push_back(mk(1, 0, 32'h0,   1,   0, 32'h000, 1, 32'h004));
    vecs.push_back(mk(1, 0, 32'h0,   0,   0, 32'h000, 1, 32'h004));
    vecs.push_back(mk(1, 0, 32'h0,   0,   0, 32'h000, 1, 32'h004));
    vecs.push_back(mk(0, 0, 32'h0,   0,   1, 32'h00C, 1, 32'h008));
    vecs.push_back(mk(0, 0, 32'h0,   1,   1, 32'h010, 1, 32'h00C));
    vecs.push_back(mk(0, 0, 32'h0,   0,   1, 32'h010, 0, 32'h00C));
    vecs.push_back(mk(0, 0, 32'h0,   1,   1, 32'h014, 1, 32'h010));
    vecs.push_back(mk(1, 0, 32'h0,   0,   1, 32'h014, 1, 32'h010));
    vecs.push_back(mk(0, 0, 32'h0,   1,   1, 32'h018, 1, 32'h014));
    vecs.push_back(mk(0, 1, 32'h103, 1,   1, 32'h100, 0, 32'h014));
    vecs.push_back(mk(0, 0, 32'h0,   1,   1, 32'h104, 1, 32'h100));
    vecs.push_back(mk(0, 1, 32'h040, 1,   1, 32'h040, 0, 32'h100));
    vecs.push_back(mk(0, 1, 32'h200, 0,   1, 32'h040, 0, 32'h100));
    vecs.push_back(mk(0, 0, 32'h0,   0,   1, 32'h040, 0, 32'h100));
    vecs.push_back(mk(0, 0, 32'h0,   1,   1, 32'h200, 0, 32'h100));
    vecs.push_back(mk(0, 0, 32'h0,   1,   1, 32'h204, 1, 32'h200));
    vecs.push_back(mk(1, 0, 32'h0,   1,   0, 32'h000, 1, 32'h200));
    vecs.push_back(mk(1, 1, 32'h300, 0,   1, 32'h300, 0, 32'h200));
    vecs.push_back(mk(0, 0, 32'h0,   1,   1, 32'h304, 1, 32'h300));
    vecs.push_back(mk(0, 1, 32'h400, 0,   1, 32'h304, 0, 32'h300));
    vecs.push_back(mk(0, 1, 32'h502, 0,   1, 32'h304, 0, 32'h300));
    vecs.push_back(mk(0, 0, 32'h0,   1,   1, 32'h500, 0, 32'h300));
    vecs.push_back(mk(0, 0, 32'h0,   1,   1, 32'h504, 1, 32'h500));
    vecs.push_back(mk(1, 1, 32'h600, 1,   1, 32'h600, 0, 32'h500));
    vecs.push_back(mk(0, 0, 32'h0,   1,   1, 32'h604, 1, 32'h600));

    reset = 1'b0;
    imem_ack = 1'b0;
    foreach (vecs[i]) begin
      stall_in = vecs[i].stall; branch_taken = vecs[i].br;
      branch_target = vecs[i].tgt; imem_ack = vecs[i].ack;
      step();
      check($sformatf("row%0d_req", i), imem_req, vecs[i].e_req);
      if (vecs[i].e_req) check($sformatf("row%0d_addr", i), imem_addr, vecs[i].e_addr);
      check($sformatf("row%0d_valid", i), valid_out, vecs[i].e_valid);
      check($sformatf("row%0d_pc", i), pc_out, vecs[i].e_pc);
      if (vecs[i].e_valid) check($sformatf("row%0d_instr", i), instr_out, vecs[i].e_pc);
    end
    stall_in = 1'b0; branch_taken = 1'b0; imem_ack = 1'b0; branch_target = '0;

    // Scoreboard stream under random stall/ack; wrap instance runs with ack every cycle.
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    exp_fetch = 32'h0; exp_valid = 1'b0; exp_pc = 32'h0;
    sb.delete();
    for (int k = 0; k < 300; k++) begin
      if (imem_req) check("sb_addr", imem_addr, exp_fetch);
      s = ($urandom_range(0, 3) == 0);
      a = imem_req && ($urandom_range(0, 4) != 0);
      stall_in = s; imem_ack = a;
      if (a) begin
        sb.push_back(exp_fetch);
        exp_fetch += 32'd4;
      end
      step();
      if (!s) begin
        check("sb_valid", valid_out, 32'(sb.size() != 0));
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("sb_pc", pc_out, e);
          check("sb_instr", instr_out, e);
          check("sb_imm", 32'(imm_out), 32'(e[9:0]));
          exp_valid = 1'b1; exp_pc = e;
        end else begin
          exp_valid = 1'b0;
        end
      end else begin
        check("sb_stall_valid", valid_out, exp_valid);
        if (exp_valid) check("sb_stall_pc", pc_out, exp_pc);
      end

      wa = WRAP_PC + 32'(4 * k);
      check("w_req", w_req, 1'b1);
      check("w_addr", w_addr, wa);
      if (k == 0) begin
        check("w_valid0", w_valid, 1'b0);
      end else begin
        wp = WRAP_PC + 32'(4 * (k - 1));
        wi = wp ^ WKEY;
        check("w_valid", w_valid, 1'b1);
        check("w_pc", w_pc, wp);
        check("w_instr", w_instr, wi);
        check("w_imm", 32'(w_imm), 32'(wi[9:0]));
        check("w_opc", 32'(w_opc), 32'(wi[31:26]));
      end
    end

    // Async reset in the middle of a HOLD cycle, then clean restart.
    stall_in = 1'b0; imem_ack = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    imem_ack = 1'b1;
    step();
    stall_in = 1'b1;
    step();
    check("hold_req", imem_req, 1'b0);
    check("hold_valid", valid_out, 1'b1);
    check("hold_pc", pc_out, 32'h0);
    #2 reset = 1'b1;
    #1;
    check("arst_req", imem_req, 1'b0);
    check("arst_addr", imem_addr, 32'h0);
    check("arst_valid", valid_out, 1'b0);
    check("arst_instr", instr_out, 32'h0);
    check("arst_pc", pc_out, 32'h0);
    check("arst_imm", 32'(imm_out), 32'h0);
    check("arst_opc", 32'(opcode_out), 32'h0);
    step();
    check("rst_ack_req", imem_req, 1'b0);
    check("rst_ack_valid", valid_out, 1'b0);
    reset = 1'b0; stall_in = 1'b0; imem_ack = 1'b0;
    step();
    check("rel_req", imem_req, 1'b1);
    check("rel_addr", imem_addr, 32'h0);
    check("rel_valid", valid_out, 1'b0);
    imem_ack = 1'b1;
    step();
    check("rel_pc0", pc_out, 32'h0);
    check("rel_valid0", valid_out, 1'b1);
    step();
    check("rel_pc4", pc_out, 32'h4);
    imem_ack = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port stall_in  input  1  downstream not accepting; output register holds.
REQ-005 SHALL have port branch_taken  input  1  single-cycle redirect request.
REQ-006 SHALL have port branch_target  input  32  redirect address; bits [1:0] forced to 0.
REQ-007 SHALL have port imem_req  output  1  instruction-memory read request.
REQ-008 SHALL have port imem_addr  output  32  registered request address, stable while imem_req high and unacknowledged.
REQ-009 SHALL have port imem_ack  input  1  read data valid this cycle; meaningful only when imem_req=1.
REQ-010 SHALL have port imem_rdata  input  32  instruction word.
REQ-011 SHALL have port valid_out  output  1  instr_out/pc_out/imm_out/opcode_out hold a live instruction.
REQ-012 SHALL have ports instr_out  output  32, pc_out  output  32 (address of instr_out), imm_out  output  10 (= instr_out[9:0], feeds zero-extender), opcode_out  output  6 (= instr_out[31:26]).

Function
REQ-013 SHALL implement states FETCH (imem_req=1), HOLD (imem_req=0, word parked), DRAIN (imem_req=1 on stale address, data discarded).
REQ-014 FETCH, ack, !stall_in: SHALL load output register from imem_rdata, valid_out<=1, pc<=pc+4, issue next request at pc+4 next cycle.
REQ-015 FETCH, ack, stall_in: SHALL capture imem_rdata in hold register, pc<=pc+4, go HOLD; outputs unchanged.
REQ-016 FETCH, no ack, !stall_in: SHALL set valid_out<=0 (bubble); request stays high, address unchanged.
REQ-017 FETCH, no ack, stall_in: SHALL hold all outputs; request stays high.
REQ-018 HOLD, stall_in: SHALL remain in HOLD. HOLD, !stall_in: SHALL move hold register to outputs, valid_out<=1, go FETCH.
REQ-019 branch_taken SHALL have priority over all other events: pc<=branch_target & ~3, valid_out<=0, hold register discarded, regardless of stall_in.
REQ-020 branch_taken in FETCH with ack same cycle, or in HOLD: SHALL drop that data and go FETCH at the target next cycle.
REQ-021 branch_taken in FETCH without ack: SHALL go DRAIN; DRAIN keeps old imem_addr until ack, drops data, then FETCH at target.
REQ-022 branch_taken during DRAIN: SHALL overwrite pc with the newest target; remain DRAIN.
REQ-023 pc arithmetic SHALL be modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
REQ-024 Fetch-to-output latency SHALL be 1 cycle after the ack edge; throughput 1 instruction/cycle with ack every cycle.

Reset
REQ-025 On reset: state=FETCH, pc=RESET_PC, imem_addr=RESET_PC, imem_req=0, valid_out=0, instr_out/pc_out=0, imm_out=0, opcode_out=0, hold register cleared.
REQ-026 imem_req SHALL go high the first cycle after reset deasserts; reset mid-request SHALL abandon it, and any ack during reset is ignored.

Structure
REQ-027 Shared package cpu_pkg SHALL hold INSTR_W=32, IMM_W=10, OPC_W=6, the fetch state enum, and default RESET_PC.
REQ-028 SHALL be a single module; no sub-module, because pc, FSM, and hold register share one next-state block.

Verification
REQ-029 Reset released, ack every cycle, rdata=addr -> pc_out 0,4,8,12 on consecutive cycles, valid_out=1 from second cycle on.
REQ-030 stall_in high 3 cycles while an ack arrives at addr 8 -> outputs frozen at pc_out=4, HOLD entered; on release pc_out=8 next cycle, no loss or duplicate.
REQ-031 branch_taken, target 32'h0000_0103, with ack same cycle -> acked word dropped, valid_out=0, next imem_addr=32'h0000_0100.
REQ-032 branch_taken, target 0x200, while request at 0x40 is pending, ack two cycles later -> imem_addr stays 0x40 until ack, data dropped, then imem_addr=0x200.
REQ-033 RESET_PC=32'hFFFF_FFFC, continuous ack -> second fetch address 0, imm_out=instr[9:0], opcode_out=instr[31:26] checked each cycle.
REQ-034 reset asserted asynchronously mid-HOLD -> all outputs 0 and imem_req=0 before the next clock edge.
